// File: rtl/pcie_x1_top_rxdet_ctl.sv
// pcie_x1_top_rxdet_ctl: PIPE receiver-detect sequencer and PCS readiness strobes (PCLK domain)
// Ports: PCLK clock, RESET_n async active-low reset;
//   ffs_plol, ffs_pcie_done, ffs_pcie_con: SERDES PLL-lock and detect status (plol/done are 2-flop synchronised);
//   TxDetectRx_Loopback, TxElecIdle, PowerDown: MAC PIPE controls;
//   ffc_pcie_det_en, ffc_pcie_ct: SERDES detect enable and strobe;
//   pcs_wait_done, start_mask, detsm_done, pcie_con_x, PhyStatus: registered qualifiers to the PIPE shim.
module pcie_x1_top_rxdet_ctl #(
  parameter logic [15:0] PLL_WAIT_CNT  = 16'd1000,
  parameter logic [15:0] DET_SETUP_CNT = 16'd16,
  parameter logic [3:0]  CT_WIDTH      = 4'd4,
  parameter logic [15:0] DET_TIMEOUT   = 16'd4000,
  parameter logic [15:0] MASK_CNT      = 16'd256
) (
  input  logic       PCLK,
  input  logic       RESET_n,
  input  logic       ffs_plol,
  input  logic       TxDetectRx_Loopback,
  input  logic       TxElecIdle,
  input  logic [1:0] PowerDown,
  input  logic       ffs_pcie_done,
  input  logic       ffs_pcie_con,
  output logic       ffc_pcie_det_en,
  output logic       ffc_pcie_ct,
  output logic       pcs_wait_done,
  output logic       start_mask,
  output logic       detsm_done,
  output logic       pcie_con_x,
  output logic       PhyStatus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, DONE, RELEASE} state_t;
  state_t state;
  logic plol_m, plol_s, done_m, done_s, done_d;
  logic [15:0] pll_cnt, ph_cnt, mask_cnt, ph_inc;
  logic pll_ok, det_req, abort, masked, done_edge, setup_end, ct_end, timeout;
  // a synchronised plol aborts one cycle ahead of the registered pcs_wait_done drop
  assign pll_ok    = pcs_wait_done & ~plol_s;
  assign det_req   = TxDetectRx_Loopback & TxElecIdle & (PowerDown == 2'b10) & pcs_wait_done;
  assign abort     = ~pll_ok | (PowerDown != 2'b10);
  assign masked    = (state != IDLE) | (PowerDown != 2'b00);
  assign done_edge = done_s & ~done_d;
  assign ph_inc    = ph_cnt + {15'd0, ph_cnt != 16'hFFFF};
  assign setup_end = ph_cnt >= DET_SETUP_CNT;
  assign ct_end    = {1'b0, ph_cnt} + 17'd1 >= 17'(CT_WIDTH);
  assign timeout   = {1'b0, ph_cnt} + 17'd1 >= {1'b0, DET_TIMEOUT};
  always_ff @(posedge PCLK or negedge RESET_n)
    if (!RESET_n) begin
      {plol_m, plol_s} <= 2'b11;
      {done_m, done_s, done_d} <= 3'b000;
      pll_cnt <= '0;
      pcs_wait_done <= 1'b0;
      mask_cnt <= '0;
      start_mask <= 1'b1;
    end else begin
      plol_m <= ffs_plol;
      plol_s <= plol_m;
      done_m <= ffs_pcie_done;
      done_s <= done_m;
      done_d <= done_s;
      pll_cnt <= plol_s ? '0 : pll_cnt + {15'd0, pll_cnt != PLL_WAIT_CNT};
      pcs_wait_done <= ~plol_s & (pll_cnt == PLL_WAIT_CNT);
      mask_cnt <= masked ? '0 : mask_cnt + {15'd0, mask_cnt != MASK_CNT};
      // drop on the MASK_CNT-th unmasked cycle
      start_mask <= masked | ({1'b0, mask_cnt} + 17'd1 < {1'b0, MASK_CNT});
    end
  always_ff @(posedge PCLK or negedge RESET_n)
    if (!RESET_n) begin
      state <= IDLE;
      ph_cnt <= '0;
      ffc_pcie_det_en <= 1'b0;
      ffc_pcie_ct <= 1'b0;
      detsm_done <= 1'b0;
      PhyStatus <= 1'b0;
      pcie_con_x <= 1'b0;
    end else begin
      detsm_done <= 1'b0;
      PhyStatus <= 1'b0;
      ph_cnt <= ph_inc;
      case (state)
        IDLE: if (det_req) begin
          state <= SETUP;
          ph_cnt <= '0;
          ffc_pcie_det_en <= 1'b1;
        end
        SETUP, STROBE, WAIT: if (abort) begin
          state <= IDLE;
          ph_cnt <= '0;
          ffc_pcie_det_en <= 1'b0;
          ffc_pcie_ct <= 1'b0;
        end else if (state == SETUP && setup_end) begin
          state <= STROBE;
          ph_cnt <= '0;
          ffc_pcie_ct <= 1'b1;
        end else if (state == STROBE && ct_end) begin
          state <= WAIT;
          ph_cnt <= '0;
          ffc_pcie_ct <= 1'b0;
        end else if (state == WAIT && (done_edge | timeout)) begin
          state <= DONE;
          ph_cnt <= '0;
          ffc_pcie_det_en <= 1'b0;
          detsm_done <= 1'b1;
          PhyStatus <= 1'b1;
          pcie_con_x <= done_edge & ffs_pcie_con;
        end
        DONE: begin
          state <= RELEASE;
          ph_cnt <= '0;
        end
        RELEASE: if (!TxDetectRx_Loopback) begin
          state <= IDLE;
          ph_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          ph_cnt <= '0;
        end
      endcase
    end
endmodule
